// File: rtl/alu_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_access_arbiter_if
// Description : Bundles the requester, response and ALU-side signals of the
//               ALU access arbiter. The slave modport is the arbiter's view.
//               The master modport is the surrounding system's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_access_arbiter_if #(
    parameter int WIDTH = 4
);
    // Requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_x;
    logic [WIDTH-1:0] req0_y;
    // Requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_x;
    logic [WIDTH-1:0] req1_y;
    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    // ALU side
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [1:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;

    modport slave (
        input  req0_valid, req0_op, req0_x, req0_y,
        input  req1_valid, req1_op, req1_x, req1_y,
        input  rsp_ready, alu_result,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result,
        output alu_x, alu_y, alu_ctrl
    );

    modport master (
        output req0_valid, req0_op, req0_x, req0_y,
        output req1_valid, req1_op, req1_x, req1_y,
        output rsp_ready, alu_result,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result,
        input  alu_x, alu_y, alu_ctrl
    );
endinterface
`default_nettype wire

// File: rtl/alu_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_access_arbiter
// Description : Round-robin arbiter that lets two requesters share one
//               registered ALU. It accepts one operation at a time and holds
//               the ALU inputs for the ALU latency. It then returns the
//               captured result, tagged with the requester ID.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_access_arbiter #(
    parameter int WIDTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  wire                  clk,
    input  wire                  rst_n,
    alu_access_arbiter_if.slave  bus
);
    localparam int c_CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last_grant;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_result;
    logic [WIDTH-1:0]   r_alu_x;
    logic [WIDTH-1:0]   r_alu_y;
    logic [1:0]         r_alu_ctrl;

    logic               w_grant0;
    logic               w_grant1;
    logic [1:0]         w_win_op;
    logic [WIDTH-1:0]   w_win_x;
    logic [WIDTH-1:0]   w_win_y;

    // Round-robin grant: a lone requester always wins; on a tie the requester
    // that was not granted last time wins.
    always_comb begin
        w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
        w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
        w_win_op = w_grant1 ? bus.req1_op : bus.req0_op;
        w_win_x  = w_grant1 ? bus.req1_x  : bus.req0_x;
        w_win_y  = w_grant1 ? bus.req1_y  : bus.req0_y;
    end

    // The ready signals are gated with rst_n so they stay low while reset is
    // asserted, even though the state already reads IDLE.
    assign bus.req0_ready = rst_n && (r_state == IDLE) && w_grant0;
    assign bus.req1_ready = rst_n && (r_state == IDLE) && w_grant1;

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.alu_x      = r_alu_x;
    assign bus.alu_y      = r_alu_y;
    assign bus.alu_ctrl   = r_alu_ctrl;

    // Transaction FSM: accept -> hold ALU inputs for the latency -> respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_alu_x      <= '0;
            r_alu_y      <= '0;
            r_alu_ctrl   <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_alu_ctrl   <= w_win_op;
                        r_alu_x      <= w_win_x;
                        r_alu_y      <= w_win_y;
                        r_rsp_id     <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_cnt        <= c_CNT_W'(ALU_LATENCY);
                        r_state      <= EXEC;
                    end else begin
                        r_alu_ctrl   <= 2'b00;
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        r_rsp_result <= bus.alu_result;
                        r_rsp_valid  <= 1'b1;
                        r_alu_ctrl   <= 2'b00;
                        r_state      <= RESP;
                    end else begin
                        r_cnt        <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_access_arbiter
// Description : Self-checking bench for alu_access_arbiter. It contains a
//               behavioural one-cycle ALU, a table of directed transactions,
//               and hand-written backpressure and mid-operation reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_access_arbiter;
    localparam int c_WIDTH = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    alu_access_arbiter_if #(.WIDTH(c_WIDTH)) bus ();

    alu_access_arbiter #(
        .WIDTH       (c_WIDTH),
        .ALU_LATENCY (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural registered ALU: off gives 0, add/sub wrap, no-op passes x.
    always_ff @(posedge clk) begin
        case (bus.alu_ctrl)
            2'b01:   bus.alu_result <= bus.alu_x + bus.alu_y;
            2'b10:   bus.alu_result <= bus.alu_x - bus.alu_y;
            2'b11:   bus.alu_result <= bus.alu_x;
            default: bus.alu_result <= '0;
        endcase
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit       do_rst;
        bit       v0;
        bit [1:0] op0;
        bit [3:0] x0;
        bit [3:0] y0;
        bit       v1;
        bit [1:0] op1;
        bit [3:0] x1;
        bit [3:0] y1;
        bit       exp_id;
        bit [3:0] exp_res;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // The caller sets the requester inputs at a negedge. This task checks the
    // grant, the accept, the ALU hold, the response latency and content, and
    // the backpressure hold. It ends at a negedge with rsp_ready low.
    task automatic run_txn(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                           input logic id, input logic [3:0] res, input int hold);
        int lat;
        bit got;
        #1;
        check("req0_ready_grant", {31'd0, bus.req0_ready}, {31'd0, id == 1'b0});
        check("req1_ready_grant", {31'd0, bus.req1_ready}, {31'd0, id == 1'b1});
        @(posedge clk); #1;
        check("alu_ctrl_accept", {30'd0, bus.alu_ctrl}, {30'd0, op});
        check("alu_x_accept",    {28'd0, bus.alu_x},    {28'd0, x});
        check("alu_y_accept",    {28'd0, bus.alu_y},    {28'd0, y});
        // Disturb the winner's inputs. They must have no effect after the accept.
        if (id == 1'b0) begin
            bus.req0_x = ~bus.req0_x; bus.req0_y = ~bus.req0_y; bus.req0_op = ~bus.req0_op;
        end else begin
            bus.req1_x = ~bus.req1_x; bus.req1_y = ~bus.req1_y; bus.req1_op = ~bus.req1_op;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                check("alu_ctrl_held", {30'd0, bus.alu_ctrl}, {30'd0, op});
                check("alu_x_held",    {28'd0, bus.alu_x},    {28'd0, x});
                check("busy_ready",    {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
            end
            if (bus.rsp_valid) got = 1'b1;
        end
        check("rsp_latency", lat, 2);
        check("rsp_id",      {31'd0, bus.rsp_id},     {31'd0, id});
        check("rsp_result",  {28'd0, bus.rsp_result}, {28'd0, res});
        check("alu_ctrl_resp", {30'd0, bus.alu_ctrl}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid",  {31'd0, bus.rsp_valid},  32'd1);
            check("hold_id",     {31'd0, bus.rsp_id},     {31'd0, id});
            check("hold_result", {28'd0, bus.rsp_result}, {28'd0, res});
            check("hold_ready",  {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        end
        @(negedge clk);
        check("resp_ready_low", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
        check("alu_ctrl_idle",  {30'd0, bus.alu_ctrl},  32'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        bus.req0_valid = v.v0; bus.req0_op = v.op0; bus.req0_x = v.x0; bus.req0_y = v.y0;
        bus.req1_valid = v.v1; bus.req1_op = v.op1; bus.req1_x = v.x1; bus.req1_y = v.y1;
    endtask

    initial begin
        vec_t v;
        rst_n          = 1'b0;
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b01; bus.req0_x = 4'h0; bus.req0_y = 4'h0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 2'b00; bus.req1_x = 4'h0; bus.req1_y = 4'h0;

        //           rst  v0 op0    x0       y0       v1 op1    x1       y1       id  res
        vecs[0] = '{1'b0, 1, 2'b01, 4'b1010, 4'b0101, 0, 2'b00, 4'b0000, 4'b0000, 0, 4'b1111};
        vecs[1] = '{1'b0, 0, 2'b00, 4'b0000, 4'b0000, 1, 2'b10, 4'b1100, 4'b0110, 1, 4'b0110};
        vecs[2] = '{1'b0, 0, 2'b00, 4'b0000, 4'b0000, 1, 2'b10, 4'b0111, 4'b0011, 1, 4'b0100};
        vecs[3] = '{1'b1, 1, 2'b01, 4'b0001, 4'b0010, 1, 2'b10, 4'b1000, 4'b0001, 0, 4'b0011};
        vecs[4] = '{1'b0, 1, 2'b01, 4'b0001, 4'b0010, 1, 2'b10, 4'b1000, 4'b0001, 1, 4'b0111};
        vecs[5] = '{1'b0, 1, 2'b01, 4'b0001, 4'b0010, 1, 2'b10, 4'b1000, 4'b0001, 0, 4'b0011};
        vecs[6] = '{1'b0, 1, 2'b01, 4'b0001, 4'b0010, 1, 2'b10, 4'b1000, 4'b0001, 1, 4'b0111};
        vecs[7] = '{1'b0, 1, 2'b11, 4'b1111, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0, 4'b1111};
        vecs[8] = '{1'b0, 1, 2'b00, 4'b1111, 4'b0101, 0, 2'b00, 4'b0000, 4'b0000, 0, 4'b0000};

        // Reset state, with req0 valid while reset is held.
        #12;
        check("rst_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
        check("rst_rsp_id",     {31'd0, bus.rsp_id},     32'd0);
        check("rst_rsp_result", {28'd0, bus.rsp_result}, 32'd0);
        check("rst_alu_xy",     {24'd0, bus.alu_x, bus.alu_y}, 32'd0);
        check("rst_alu_ctrl",   {30'd0, bus.alu_ctrl},   32'd0);
        check("rst_ready",      {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_alu_ctrl", {30'd0, bus.alu_ctrl}, 32'd0);

        // Table-driven transactions.
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            if (v.do_rst) begin
                apply_vec('{default: 0});
                do_reset();
            end
            apply_vec(v);
            if (v.exp_id == 1'b0) run_txn(v.op0, v.x0, v.y0, 1'b0, v.exp_res, 0);
            else                  run_txn(v.op1, v.x1, v.y1, 1'b1, v.exp_res, 0);
        end

        // Wrap-around with 5 cycles of backpressure. r1 wins the tie here.
        bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_x = 4'b0001; bus.req0_y = 4'b0001;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b01; bus.req1_x = 4'b1111; bus.req1_y = 4'b0001;
        run_txn(2'b01, 4'b1111, 4'b0001, 1'b1, 4'b0000, 5);

        // Reset in the middle of EXEC.
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_x = 4'b0011; bus.req0_y = 4'b0001;
        @(posedge clk); #1;
        check("mid_accept_ctrl", {30'd0, bus.alu_ctrl}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl",  {30'd0, bus.alu_ctrl}, 32'd0);
        check("mid_rst_xy",    {24'd0, bus.alu_x, bus.alu_y}, 32'd0);
        check("mid_rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("mid_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b10; bus.req1_x = 4'b0101; bus.req1_y = 4'b0001;
        #1;
        check("post_rst_tie_r0", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd2);
        bus.req0_valid = 1'b0;
        run_txn(2'b10, 4'b0101, 4'b0001, 1'b1, 4'b0100, 0);
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        check("final_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
